mtr_drv_pwm: RTL and testbench
==============================

// Module: mtr_drv_pwm
// PURPOSE
//  Downstream of the heading PID. Converts signed 11-bit lft_spd/rght_spd into
//  complementary half-bridge gate drives (PWM1 high-side, PWM2 low-side) for each motor.
//  Uses one shared 11-bit PWM carrier. Duty is updated only at period boundaries.
//  Dead-time is inserted on every edge, so PWM1 and PWM2 of a channel are never high together.
// PARAMETERS
//  NONOVERLAP  32  dead-time in clk cycles (both gates low) after each pwm_sig transition; range 1..255
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   reset, asynchronous, active-low
//  lft_spd    in   11  signed left speed from PID, -1024..+1023
//  rght_spd   in   11  signed right speed from PID, -1024..+1023
//  lftPWM1    out  1   left high-side gate
//  lftPWM2    out  1   left low-side gate
//  rghtPWM1   out  1   right high-side gate
//  rghtPWM2   out  1   right low-side gate
//  pwm_sync   out  1   high for the single cycle in which cnt==11'h7FF (duty latch cycle)
// BEHAVIOUR
//  Reset values:
//   - all four PWM outputs 0; pwm_sync 0
//   - cnt=0; both duty regs=11'h400; dead-time active on both channels
//  Carrier: 11-bit up-counter cnt, +1 every clk, wraps 7FF->000; period = 2048 clks.
//  Duty conversion: duty = spd + 11'h400 (MSB inversion, offset binary).
//   - -1024 -> 000; 0 -> 400; +1023 -> 7FF. No other arithmetic.
//  Duty latch: in the cycle cnt==7FF, duty_q <= converted spd; applies from cnt==000.
//   - spd changes at any other time have no effect on the current period.
//  pwm_sig (per channel, combinational) = (cnt < duty_q).
//   - duty 000 -> always low; duty 7FF -> low only in the cnt==7FF cycle.
//  Dead-time, per channel, independent, registered outputs:
//   - sig_q <= pwm_sig each clk. A transition is a cycle k in which pwm_sig != sig_q.
//   - Transition at k: PWM1=PWM2=0 from edge k+1; dead_cnt loads NONOVERLAP-1.
//   - dead_cnt decrements each clk while non-zero.
//   - When dead_cnt reaches 0 with no new transition, next edge drives PWM1=pwm_sig, PWM2=~pwm_sig.
//   - Result: both gates are low for exactly NONOVERLAP clks after the last transition.
//  Retrigger: a transition during dead-time reloads dead_cnt (no partial pulse).
//   - Any pulse narrower than NONOVERLAP is therefore fully suppressed.
//  Outputs: PWM1 & PWM2 is never 1 in any cycle, including across reset release.
//  After reset release:
//   - both gates stay low for NONOVERLAP clks, then follow duty 400 (zero speed).
//  Reset mid-operation: outputs drop to 0 asynchronously; cnt and duty return to reset values.
//  Latency: a new spd takes effect at most 2048 clks + NONOVERLAP+1 clks after it is applied.
// TESTING (NONOVERLAP=32)
//  1. Reset, lft_spd=rght_spd=0:
//     - each PWM1 high 992 clks and PWM2 high 992 clks per 2048-clk period
//     - PWM1&PWM2 never 1
//  2. lft_spd=11'h3FF:
//     - lftPWM1 high 2015 clks/period (33 low: 7FF dip plus retrigger)
//     - lftPWM2 never high
//  3. lft_spd=11'h400 (-1024):
//     - lftPWM1 never high
//     - lftPWM2 continuously high after the initial 32-clk dead-time
//  4. lft_spd changed 0->11'h200 at cnt=100:
//     - current period keeps duty 400
//     - pwm_sync pulses at cnt=7FF
//     - new duty 600 gives lftPWM1 high 1504 clks in the next period
//  5. lft_spd=+256, rght_spd=-256:
//     - lft duty 500 and rght duty 300
//     - lftPWM1 high 1248 clks, rghtPWM1 high 736 clks per period; channels independent
//  6. rst_n low during lftPWM1 high:
//     - all outputs 0 at once; cnt=0
//     - after release, gates stay low 32 clks, then 50% pattern resumes

Source files
------------

// File: rtl/mtr_drv_pwm.sv
// mtr_drv_pwm: dual-channel complementary half-bridge PWM driver.
// The left and right channels share one 11-bit carrier. The signed speed inputs
// become offset-binary duty values that are latched once per period. Each
// channel has a retriggerable dead-time stage. It guarantees that the high-side
// gate and the low-side gate of a bridge are never on together.
module mtr_drv_pwm #(
    parameter int unsigned NONOVERLAP = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [10:0] lft_spd,
    input  logic signed [10:0] rght_spd,
    output logic               lftPWM1,
    output logic               lftPWM2,
    output logic               rghtPWM1,
    output logic               rghtPWM2,
    output logic               pwm_sync
);

    localparam int unsigned CH        = 2;
    localparam int unsigned IDX_LFT   = 0;
    localparam int unsigned IDX_RGHT  = 1;
    localparam logic [10:0] CNT_LAST  = 11'h7FF;
    localparam logic [10:0] CNT_PRE   = 11'h7FE;
    localparam logic [10:0] DUTY_ZERO = 11'h400;
    localparam logic [7:0]  DEAD_LOAD = 8'(NONOVERLAP - 1);

    // Shared carrier.
    logic [10:0] cnt;

    // Per-channel duty path.
    logic [10:0] spd_duty [CH];
    logic [10:0] duty_q   [CH];

    // Per-channel dead-time path.
    logic [CH-1:0] pwm_sig;
    logic [CH-1:0] sig_q;
    logic [CH-1:0] pwm1_q;
    logic [CH-1:0] pwm2_q;
    logic [7:0]    dead_cnt [CH];

    // Offset-binary conversion (spd + 0x400 == MSB inversion) and carrier compare.
    always_comb begin
        spd_duty[IDX_LFT]  = {~lft_spd[10],  lft_spd[9:0]};
        spd_duty[IDX_RGHT] = {~rght_spd[10], rght_spd[9:0]};
        pwm_sig = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            pwm_sig[i] = (cnt < duty_q[i]);
        end
    end

    // Free-running carrier. pwm_sync is registered one count early so that it
    // is high exactly during the cnt == 7FF cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            pwm_sync <= 1'b0;
        end else begin
            cnt      <= cnt + 11'd1;
            pwm_sync <= (cnt == CNT_PRE);
        end
    end

    // Duty is latched only in the last count of the period and applies from cnt == 000.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CH; i++) begin
                duty_q[i] <= DUTY_ZERO;
            end
        end else if (cnt == CNT_LAST) begin
            for (int unsigned i = 0; i < CH; i++) begin
                duty_q[i] <= spd_duty[i];
            end
        end
    end

    // Dead-time insertion. Any pwm_sig edge reloads the counter and forces both
    // gates low. The gates follow pwm_sig again only after the count expires
    // with no further edge. sig_q resets to 1 because pwm_sig is 1 out of reset
    // (cnt 0 < duty 400). This makes the reset-loaded dead-time the only
    // blanking after release, so release gives exactly NONOVERLAP low cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q  <= '1;
            pwm1_q <= '0;
            pwm2_q <= '0;
            for (int unsigned i = 0; i < CH; i++) begin
                dead_cnt[i] <= DEAD_LOAD;
            end
        end else begin
            sig_q <= pwm_sig;
            for (int unsigned i = 0; i < CH; i++) begin
                if (pwm_sig[i] != sig_q[i]) begin
                    dead_cnt[i] <= DEAD_LOAD;
                    pwm1_q[i]   <= 1'b0;
                    pwm2_q[i]   <= 1'b0;
                end else if (dead_cnt[i] != 8'd0) begin
                    dead_cnt[i] <= dead_cnt[i] - 8'd1;
                    pwm1_q[i]   <= 1'b0;
                    pwm2_q[i]   <= 1'b0;
                end else begin
                    pwm1_q[i]   <= pwm_sig[i];
                    pwm2_q[i]   <= ~pwm_sig[i];
                end
            end
        end
    end

    // Gate outputs come directly from the registers.
    always_comb begin
        lftPWM1  = pwm1_q[IDX_LFT];
        lftPWM2  = pwm2_q[IDX_LFT];
        rghtPWM1 = pwm1_q[IDX_RGHT];
        rghtPWM2 = pwm2_q[IDX_RGHT];
    end

endmodule

// File: tb/tb_mtr_drv_pwm.sv
// Directed testbench for mtr_drv_pwm with NONOVERLAP = 32.
// Outputs are sampled on the falling clock edge. The sample taken on a
// falling edge shows the count value of the preceding rising edge.
module tb_mtr_drv_pwm;

    logic               clk;
    logic               rst_n;
    logic signed [10:0] lft_spd;
    logic signed [10:0] rght_spd;
    logic               lftPWM1;
    logic               lftPWM2;
    logic               rghtPWM1;
    logic               rghtPWM2;
    logic               pwm_sync;

    int n_checks;
    int n_fail;
    int n_ovl;

    mtr_drv_pwm #(.NONOVERLAP(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .lftPWM1  (lftPWM1),
        .lftPWM2  (lftPWM2),
        .rghtPWM1 (rghtPWM1),
        .rghtPWM2 (rghtPWM2),
        .pwm_sync (pwm_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shoot-through monitor.
    always @(negedge clk) begin
        if ((lftPWM1 && lftPWM2) || (rghtPWM1 && rghtPWM2)) n_ovl++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Returns at the falling edge where pwm_sync is high, which is the cnt == 7FF cycle.
    task automatic wait_sync(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4200 && !seen; i++) begin
            @(negedge clk);
            if (pwm_sync) seen = 1'b1;
        end
        if (!seen) chk({tag, "_sync_timeout"}, 0, 1);
    endtask

    // Call this right after the falling edge of a cnt == 7FF cycle. It samples
    // cnt 0..7FF of the next period. lft_spd is optionally changed at sample chg_idx.
    task automatic measure(input int chg_idx, input logic [10:0] chg_val,
                           output int l1, output int l2, output int r1, output int r2,
                           output int sync_n, output int sync_pos);
        l1 = 0; l2 = 0; r1 = 0; r2 = 0; sync_n = 0; sync_pos = -1;
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            if (lftPWM1)  l1++;
            if (lftPWM2)  l2++;
            if (rghtPWM1) r1++;
            if (rghtPWM2) r2++;
            if (pwm_sync) begin
                sync_n++;
                sync_pos = i;
            end
            if (i == chg_idx) lft_spd = chg_val;
        end
    endtask

    // Releases reset just after a rising edge so that the next falling edge
    // shows cnt == 0. Then it checks the 32-cycle blanking, the resumed 50%
    // pattern and the position of the first pwm_sync.
    task automatic release_check(input string tag);
        int low_n;
        int first_sync;
        int l1_at32;
        int r1_at32;
        low_n = 0; first_sync = -1; l1_at32 = 0; r1_at32 = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            if (i < 32 && !lftPWM1 && !lftPWM2 && !rghtPWM1 && !rghtPWM2) low_n++;
            if (i == 32) begin
                l1_at32 = int'(lftPWM1);
                r1_at32 = int'(rghtPWM1);
            end
            if (pwm_sync && first_sync < 0) first_sync = i;
        end
        chk({tag, "_dead_low_cycles"}, low_n, 32);
        chk({tag, "_lftPWM1_at32"}, l1_at32, 1);
        chk({tag, "_rghtPWM1_at32"}, r1_at32, 1);
        chk({tag, "_first_sync_cnt"}, first_sync, 2047);
    endtask

    int l1, l2, r1, r2, sn, sp;

    initial begin
        n_checks = 0; n_fail = 0; n_ovl = 0;
        rst_n    = 1'b0;
        lft_spd  = '0;
        rght_spd = '0;

        // Values held while reset is asserted.
        repeat (3) @(negedge clk);
        chk("rst_lftPWM1",  int'(lftPWM1),  0);
        chk("rst_lftPWM2",  int'(lftPWM2),  0);
        chk("rst_rghtPWM1", int'(rghtPWM1), 0);
        chk("rst_rghtPWM2", int'(rghtPWM2), 0);
        chk("rst_pwm_sync", int'(pwm_sync), 0);
        release_check("init");

        // Test 1: zero speed gives 992/992 on both channels.
        measure(-1, 11'h000, l1, l2, r1, r2, sn, sp);
        chk("t1_lftPWM1",  l1, 992);
        chk("t1_lftPWM2",  l2, 992);
        chk("t1_rghtPWM1", r1, 992);
        chk("t1_rghtPWM2", r2, 992);
        chk("t1_sync_n",   sn, 1);

        // Test 5: +256 gives duty 500 and -256 gives duty 300; the channels are independent.
        lft_spd = 11'sd256; rght_spd = -11'sd256;
        wait_sync("t5a"); wait_sync("t5b");
        measure(-1, 11'h000, l1, l2, r1, r2, sn, sp);
        chk("t5_lftPWM1",  l1, 1248);
        chk("t5_lftPWM2",  l2, 736);
        chk("t5_rghtPWM1", r1, 736);
        chk("t5_rghtPWM2", r2, 1248);

        // Test 2: full positive speed. The 7FF dip plus the retrigger leaves 33 low cycles.
        lft_spd = 11'h3FF;
        wait_sync("t2a"); wait_sync("t2b");
        measure(-1, 11'h000, l1, l2, r1, r2, sn, sp);
        chk("t2_lftPWM1",  l1, 2015);
        chk("t2_lftPWM2",  l2, 0);
        chk("t2_rghtPWM1", r1, 736);

        // Test 3: full negative speed keeps the low side on continuously.
        lft_spd = 11'h400;
        wait_sync("t3a"); wait_sync("t3b");
        measure(-1, 11'h000, l1, l2, r1, r2, sn, sp);
        chk("t3_lftPWM1", l1, 0);
        chk("t3_lftPWM2", l2, 2048);

        // Test 4: a speed change mid-period has no effect until the next period.
        lft_spd = '0; rght_spd = '0;
        wait_sync("t4a"); wait_sync("t4b");
        measure(100, 11'h200, l1, l2, r1, r2, sn, sp);
        chk("t4_cur_lftPWM1", l1, 992);
        chk("t4_sync_n",      sn, 1);
        chk("t4_sync_pos",    sp, 2047);
        measure(-1, 11'h000, l1, l2, r1, r2, sn, sp);
        chk("t4_new_lftPWM1", l1, 1504);
        chk("t4_new_lftPWM2", l2, 480);

        // Test 6: reset asserted while lftPWM1 is high.
        lft_spd = '0;
        wait_sync("t6a"); wait_sync("t6b");
        repeat (201) @(negedge clk);
        chk("t6_pre_lftPWM1", int'(lftPWM1), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_lftPWM1",  int'(lftPWM1),  0);
        chk("t6_async_lftPWM2",  int'(lftPWM2),  0);
        chk("t6_async_rghtPWM1", int'(rghtPWM1), 0);
        chk("t6_async_rghtPWM2", int'(rghtPWM2), 0);
        chk("t6_async_pwm_sync", int'(pwm_sync), 0);
        repeat (3) @(posedge clk);
        release_check("t6");
        measure(-1, 11'h000, l1, l2, r1, r2, sn, sp);
        chk("t6_resume_lftPWM1", l1, 992);
        chk("t6_resume_lftPWM2", l2, 992);

        chk("no_shoot_through", n_ovl, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
